ahb_lite_rif_bridge: RTL and testbench

- Second-generation AHB-Lite slave to register-interface (RIF) bridge.
- Adds a variable-latency RIF request/acknowledge handshake and address-offset-aware byte enables.
- Detects misalignment and RIF timeouts and reports them as two-cycle AHB ERROR responses.
- Sits between the AHB-Lite interconnect and a register file or peripheral whose response latency is not fixed.

---
 rtl/ahb_lite_rif_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_ahb_lite_rif_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_rif_bridge.sv
// ahb_lite_rif_bridge: AHB-Lite slave to variable-latency register interface (RIF).
// Misaligned/oversized transfers, RIF errors and RIF timeouts give a two-cycle ERROR.
// Optional write posting is compiled in when AHB_RIF_WRITE_POST_EN is defined.
module ahb_lite_rif_bridge #(
   parameter  int unsigned ADDR_WIDTH     = 12,
   parameter  int unsigned DATA_WIDTH     = 32,
   localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter  int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  rif_req,
   output logic                  rif_we,
   output logic [ADDR_WIDTH-1:0] rif_addr,
   output logic [STRB_WIDTH-1:0] rif_be,
   output logic [DATA_WIDTH-1:0] rif_wdata,
   input  logic                  rif_ack,
   input  logic                  rif_err,
   input  logic [DATA_WIDTH-1:0] rif_rdata,
   output logic                  post_err
);

   localparam int unsigned LG     = $clog2(STRB_WIDTH);
   localparam int unsigned LG_W   = (LG == 0) ? 1 : LG;
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

   // Reject unsupported bus widths at elaboration
   if (!(DATA_WIDTH == 8   || DATA_WIDTH == 16  || DATA_WIDTH == 32  || DATA_WIDTH == 64 ||
         DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512 || DATA_WIDTH == 1024))
   begin : g_bad_width
      $fatal(1, "ahb_lite_rif_bridge: unsupported DATA_WIDTH %0d", DATA_WIDTH);
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
`ifdef AHB_RIF_WRITE_POST_EN
      , ST_PCAP,
      ST_POST
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic                  we_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] hrdata_q;

   logic                  hready_c, hresp_c, req_c, we_c;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic [STRB_WIDTH-1:0] be_c;
   logic [DATA_WIDTH-1:0] wdata_c, rd_mask_c;
   logic                  accept_c, take_c, legal_c, timeout_c;
   logic                  unused_c;

`ifdef AHB_RIF_WRITE_POST_EN
   logic [ADDR_WIDTH-1:0] pb_addr_q;
   logic [2:0]            pb_size_q;
   logic [DATA_WIDTH-1:0] pb_data_q;
   logic                  pend_q, pend_ill_q, post_err_q;
`endif

   // Byte lanes covered by a legal transfer of the given size at the given address
   function automatic logic [STRB_WIDTH-1:0] lane_be(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [2:0]            size);
      logic [STRB_WIDTH-1:0] base;
      logic [LG_W-1:0]       off;
      base = {STRB_WIDTH{1'b1}} >> (STRB_WIDTH - (32'd1 << size));
      if (LG == 0) off = '0;
      else         off = LG_W'(addr);
      return base << off;
   endfunction

   assign unused_c = HTRANS[0];

   assign accept_c  = HSEL & HREADYIN & HTRANS[1];
   assign take_c    = accept_c & hready_c;
   assign legal_c   = (HSIZE <= 3'(LG)) &&
                      ((HADDR & ((ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1))) == '0);
   assign timeout_c = TO_EN && (cnt_q == CNT_W'(TO_LAST));

   // Output decode from state and latched transfer attributes only
   always_comb begin
      hready_c = 1'b1;
      hresp_c  = 1'b0;
      req_c    = 1'b0;
      we_c     = 1'b0;
      addr_c   = addr_q;
      be_c     = '0;
      wdata_c  = HWDATA;
      case (state_q)
         ST_ACCESS: begin
            hready_c = 1'b0;
            req_c    = 1'b1;
            we_c     = we_q;
            be_c     = lane_be(addr_q, size_q);
         end
         ST_ERR1: begin
            hready_c = 1'b0;
            hresp_c  = 1'b1;
         end
         ST_ERR2: hresp_c = 1'b1;
`ifdef AHB_RIF_WRITE_POST_EN
         ST_POST: begin
            hready_c = ~pend_q;
            req_c    = 1'b1;
            we_c     = 1'b1;
            addr_c   = pb_addr_q;
            be_c     = lane_be(pb_addr_q, pb_size_q);
            wdata_c  = pb_data_q;
         end
`endif
         default: ;
      endcase
   end

   // Read-data lane mask derived from the active byte enables
   always_comb begin
      rd_mask_c = '0;
      for (int i = 0; i < int'(STRB_WIDTH); i++) rd_mask_c[i*8 +: 8] = {8{be_c[i]}};
   end

   // Next-state logic
   always_comb begin
      state_t launch;
      state_d = state_q;
      launch  = ST_ERR1;
      if (legal_c) launch = ST_ACCESS;
`ifdef AHB_RIF_WRITE_POST_EN
      if (legal_c && HWRITE) launch = ST_PCAP;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: state_d = take_c ? launch : ST_IDLE;
         ST_ACCESS: begin
            if (rif_ack)        state_d = rif_err ? ST_ERR1 : ST_DONE;
            else if (timeout_c) state_d = ST_ERR1;
         end
         ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_RIF_WRITE_POST_EN
         ST_PCAP: state_d = ST_POST;
         ST_POST: begin
            if (rif_ack || timeout_c) begin
               if (pend_q)      state_d = pend_ill_q ? ST_ERR1 : ST_ACCESS;
               else if (take_c) state_d = launch;
               else             state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; async reset drops rif_req and restores HREADYOUT at once
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Address-phase latch, wait counter and read-data capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q   <= '0;
         size_q   <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         hrdata_q <= '0;
      end else begin
         if (take_c) begin
            addr_q <= HADDR;
            size_q <= HSIZE;
            we_q   <= HWRITE;
         end
         cnt_q <= (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
         if (state_q == ST_ACCESS && rif_ack && !rif_err && !we_q)
            hrdata_q <= rif_rdata & rd_mask_c;
      end
   end

`ifdef AHB_RIF_WRITE_POST_EN
   // Posted-write buffer, pending transfer tracking and failure pulse
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pb_addr_q  <= '0;
         pb_size_q  <= '0;
         pb_data_q  <= '0;
         pend_q     <= 1'b0;
         pend_ill_q <= 1'b0;
         post_err_q <= 1'b0;
      end else begin
         if (take_c && state_d == ST_PCAP) begin
            pb_addr_q <= HADDR;
            pb_size_q <= HSIZE;
         end
         if (state_q == ST_PCAP) pb_data_q <= HWDATA;
         if (state_q == ST_POST && (rif_ack || timeout_c)) begin
            pend_q <= 1'b0;
         end else if (take_c && (state_q == ST_PCAP || state_q == ST_POST)) begin
            pend_q     <= 1'b1;
            pend_ill_q <= ~legal_c;
         end
         post_err_q <= (state_q == ST_POST) &&
                       ((rif_ack && rif_err) || (!rif_ack && timeout_c));
      end
   end

   assign post_err = post_err_q;
`else
   assign post_err = 1'b0;
`endif

   assign HREADYOUT = hready_c;
   assign HRESP     = hresp_c;
   assign HRDATA    = hrdata_q;
   assign rif_req   = req_c;
   assign rif_we    = we_c;
   assign rif_addr  = addr_c;
   assign rif_be    = be_c;
   assign rif_wdata = wdata_c;

endmodule

// File: tb/tb_ahb_lite_rif_bridge.sv
// tb_ahb_lite_rif_bridge: directed vectors and corner sequences for ahb_lite_rif_bridge.
`timescale 1ns/1ps
module tb_ahb_lite_rif_bridge;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [11:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADYIN;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        rif_req;
   logic        rif_we;
   logic [11:0] rif_addr;
   logic [3:0]  rif_be;
   logic [31:0] rif_wdata;
   logic        rif_ack;
   logic        rif_err;
   logic [31:0] rif_rdata;
   logic        post_err;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_lite_rif_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .rif_req(rif_req),
      .rif_we(rif_we), .rif_addr(rif_addr), .rif_be(rif_be), .rif_wdata(rif_wdata),
      .rif_ack(rif_ack), .rif_err(rif_err), .rif_rdata(rif_rdata), .post_err(post_err)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          ack_at;     // ACCESS cycle carrying rif_ack, 0 = never
      logic        err;
      logic [31:0] rdata;
      int          exp_req;    // cycles with rif_req high
      int          exp_wait;   // data-phase cycles with HREADYOUT low
      int          exp_resp;   // data-phase cycles with HRESP high
      logic [3:0]  exp_be;
      logic [31:0] exp_hrdata;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #2;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
   endtask

   task automatic addr_phase(input logic wr, input logic [11:0] a, input logic [2:0] sz);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = a;
      HWRITE = wr;
      HSIZE  = sz;
   endtask

   // One isolated transfer: address phase, then watch the data phase to completion
   task automatic run_vec(input vec_t v, input int idx);
      int reqs, waits, resps;
      bit done, seen_req;
      string tag;
      tag = $sformatf("vec%0d", idx);
      check({tag, ".start_ready"}, 64'(HREADYOUT), 64'd1);
      addr_phase(v.wr, v.addr, v.size);
      nxt();
      bus_idle();
      HWDATA = v.wdata;
      #1;
      reqs = 0; waits = 0; resps = 0; done = 0; seen_req = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (HRESP) resps++;
         if (rif_req) begin
            reqs++;
            if (!seen_req) begin
               seen_req = 1;
               check({tag, ".rif_be"},   64'(rif_be),   64'(v.exp_be));
               check({tag, ".rif_addr"}, 64'(rif_addr), 64'(v.addr));
               check({tag, ".rif_we"},   64'(rif_we),   64'(v.wr));
               if (v.wr) check({tag, ".rif_wdata"}, 64'(rif_wdata), 64'(v.wdata));
            end
         end
         if (HREADYOUT) begin
            done = 1;
            check({tag, ".hrdata"}, 64'(HRDATA), 64'(v.exp_hrdata));
         end else begin
            waits++;
         end
         rif_ack   = rif_req && (reqs == v.ack_at);
         rif_err   = v.err;
         rif_rdata = v.rdata;
         if (!done) nxt();
      end
      rif_ack = 1'b0;
      check({tag, ".completed"}, 64'(done), 64'd1);
      check({tag, ".req_cycles"},  64'(reqs),  64'(v.exp_req));
      check({tag, ".wait_cycles"}, 64'(waits), 64'(v.exp_wait));
      check({tag, ".resp_cycles"}, 64'(resps), 64'(v.exp_resp));
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      //                wr    addr     sz    wdata          ack err   rdata          req wt rs  be     hrdata
      vecs[0]  = '{1'b0, 12'h010, 3'd2, 32'h0,          3, 1'b0, 32'hDEADBEEF,  3,  3, 0, 4'hF, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 12'h013, 3'd0, 32'hAB000000,   1, 1'b0, 32'h0,         1,  1, 0, 4'h8, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 12'h001, 3'd1, 32'h0,          0, 1'b0, 32'h0,         0,  1, 2, 4'h0, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 12'h020, 3'd2, 32'h0,          0, 1'b0, 32'h55555555, 16, 17, 2, 4'hF, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 12'h020, 3'd2, 32'h0,         16, 1'b0, 32'h0BADF00D, 16, 16, 0, 4'hF, 32'h0BADF00D};
      vecs[5]  = '{1'b0, 12'h024, 3'd2, 32'h0,          2, 1'b1, 32'h11111111,  2,  3, 2, 4'hF, 32'h0BADF00D};
      vecs[6]  = '{1'b0, 12'h000, 3'd3, 32'h0,          0, 1'b0, 32'h0,         0,  1, 2, 4'h0, 32'h0BADF00D};
      vecs[7]  = '{1'b0, 12'h012, 3'd1, 32'h0,          1, 1'b0, 32'h12345678,  1,  1, 0, 4'hC, 32'h12340000};
      vecs[8]  = '{1'b1, 12'h002, 3'd2, 32'h99999999,   0, 1'b0, 32'h0,         0,  1, 2, 4'h0, 32'h12340000};
      vecs[9]  = '{1'b0, 12'h005, 3'd0, 32'h0,          2, 1'b0, 32'hFFFFFFFF,  2,  2, 0, 4'h2, 32'h0000FF00};
      vecs[10] = '{1'b1, 12'h0FC, 3'd2, 32'hCAFEF00D,   1, 1'b0, 32'h0,         1,  1, 0, 4'hF, 32'h0000FF00};

      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = '0; HWDATA = '0; HREADYIN = 1'b1; rif_ack = 1'b0; rif_err = 1'b0; rif_rdata = '0;
      repeat (3) nxt();

      // Reset values
      check("rst.hreadyout", 64'(HREADYOUT), 64'd1);
      check("rst.hresp",     64'(HRESP),     64'd0);
      check("rst.hrdata",    64'(HRDATA),    64'd0);
      check("rst.rif_req",   64'(rif_req),   64'd0);
      check("rst.rif_we",    64'(rif_we),    64'd0);
      check("rst.rif_addr",  64'(rif_addr),  64'd0);
      check("rst.rif_be",    64'(rif_be),    64'd0);
      check("rst.post_err",  64'(post_err),  64'd0);
      HRESETn = 1'b1;
      nxt();

      // BUSY transfer and HREADYIN low: zero-wait OKAY, no RIF activity
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = 12'h010; HSIZE = 3'd2;
      nxt();
      check("busy.rif_req",   64'(rif_req),   64'd0);
      check("busy.hreadyout", 64'(HREADYOUT), 64'd1);
      HTRANS = 2'b10; HREADYIN = 1'b0;
      nxt();
      check("nordy.rif_req", 64'(rif_req), 64'd0);
      check("nordy.hresp",   64'(HRESP),   64'd0);
      HREADYIN = 1'b1;
      bus_idle();
      nxt();

      // Table of isolated transfers
      for (int i = 0; i < 11; i++) begin
`ifdef AHB_RIF_WRITE_POST_EN
         if (vecs[i].wr && vecs[i].exp_req > 0) continue;
`endif
         run_vec(vecs[i], i);
      end

      // Back-to-back reads: second address phase during DONE, no IDLE gap
      addr_phase(1'b0, 12'h000, 3'd2);
      nxt();
      bus_idle();
      #1;
      check("b2b.req1", 64'(rif_req), 64'd1);
      rif_ack = 1'b1; rif_err = 1'b0; rif_rdata = 32'hA1A1A1A1;
      nxt();
      rif_ack = 1'b0;
      check("b2b.done1_ready", 64'(HREADYOUT), 64'd1);
      check("b2b.hrdata1",     64'(HRDATA),    64'hA1A1A1A1);
      addr_phase(1'b0, 12'h004, 3'd2);
      nxt();
      bus_idle();
      check("b2b.req2",      64'(rif_req),   64'd1);
      check("b2b.addr2",     64'(rif_addr),  64'h004);
      check("b2b.wait2",     64'(HREADYOUT), 64'd0);
      rif_ack = 1'b1; rif_rdata = 32'hB2B2B2B2;
      nxt();
      rif_ack = 1'b0;
      check("b2b.hrdata2", 64'(HRDATA),    64'hB2B2B2B2);
      check("b2b.ready2",  64'(HREADYOUT), 64'd1);
      nxt();

      // Reset asserted in the middle of an ACCESS
      addr_phase(1'b0, 12'h008, 3'd2);
      nxt();
      bus_idle();
      check("rstmid.req_before", 64'(rif_req), 64'd1);
      HRESETn = 1'b0;
      #1;
      check("rstmid.req_after",   64'(rif_req),   64'd0);
      check("rstmid.ready_after", 64'(HREADYOUT), 64'd1);
      nxt();
      HRESETn = 1'b1;
      nxt();
      check("rstmid.idle_req", 64'(rif_req), 64'd0);

`ifdef AHB_RIF_WRITE_POST_EN
      // Posted write followed by an immediate read that waits for the post
      addr_phase(1'b1, 12'h030, 3'd2);
      nxt();
      HWDATA = 32'h5A5A5A5A;
      addr_phase(1'b0, 12'h034, 3'd2);
      #1;
      check("post.write_zero_wait", 64'(HREADYOUT), 64'd1);
      nxt();
      bus_idle();
      #1;
      check("post.req",   64'(rif_req),   64'd1);
      check("post.we",    64'(rif_we),    64'd1);
      check("post.addr",  64'(rif_addr),  64'h030);
      check("post.wdata", 64'(rif_wdata), 64'h5A5A5A5A);
      check("post.read_stall", 64'(HREADYOUT), 64'd0);
      rif_ack = 1'b1; rif_err = 1'b0;
      nxt();
      rif_ack = 1'b0;
      check("post.rd_req",  64'(rif_req),   64'd1);
      check("post.rd_we",   64'(rif_we),    64'd0);
      check("post.rd_addr", 64'(rif_addr),  64'h034);
      check("post.rd_wait", 64'(HREADYOUT), 64'd0);
      rif_ack = 1'b1; rif_rdata = 32'h77665544;
      nxt();
      rif_ack = 1'b0;
      check("post.rd_ready",  64'(HREADYOUT), 64'd1);
      check("post.rd_hrdata", 64'(HRDATA),    64'h77665544);
      nxt();

      // Posted write failing on the RIF side pulses post_err once
      addr_phase(1'b1, 12'h040, 3'd2);
      nxt();
      HWDATA = 32'h01020304;
      bus_idle();
      nxt();
      check("perr.req",       64'(rif_req),  64'd1);
      check("perr.pulse_pre", 64'(post_err), 64'd0);
      rif_ack = 1'b1; rif_err = 1'b1;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         nxt();
         rif_ack = 1'b0; rif_err = 1'b0;
         if (post_err) cnt++;
      end
      check("perr.pulse_cycles", 64'(cnt), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
